ram_march_bist: RTL and testbench

//  March C- built-in self-test initiator for the flop-based single-port RAMs.

---
 rtl/ram_march_bist.sv | 194 +++++++++++++++++++
 tb/tb_ram_march_bist.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_bist.sv
// March C- self-test initiator for a single-port RAM with combinational read.
// It drives one op per cycle and stops at the first read mismatch, capturing where it happened.
module ram_march_bist #(
    parameter int                ADDR_W = 7,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BG     = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] D0        = BG;
    localparam logic [DATA_W-1:0] D1        = ~BG;

    state_t            r_state,     w_state_nxt;
    logic [2:0]        r_elem,      w_elem_nxt;
    logic              r_phase,     w_phase_nxt;
    logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_pass,      w_pass_nxt;
    logic [2:0]        r_fail_elem, w_fail_elem_nxt;
    logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_nxt;
    logic [DATA_W-1:0] r_fail_data, w_fail_data_nxt;
    logic              r_en,        w_en_nxt;
    logic              r_we,        w_we_nxt;
    logic [DATA_W-1:0] r_wdata,     w_wdata_nxt;

    logic              w_is_read;
    logic              w_down;
    logic              w_two_ops;
    logic              w_last_addr;
    logic              w_mismatch;
    logic [DATA_W-1:0] w_exp;

    // Decode the op currently on the RAM port: phase 0 is the read of an element, phase 1 its write.
    always_comb begin
        w_is_read   = (r_elem != 3'd0) && !r_phase;
        w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
        w_two_ops   = (r_elem != 3'd0) && (r_elem != 3'd5);
        w_exp       = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? D1 : D0;
        w_mismatch  = w_is_read && (ram_rdata != w_exp);
        w_last_addr = w_down ? (r_addr == ADDR_ZERO) : (r_addr == ADDR_MAX);
    end

    // Sequencing: advance phase, then address, then element; a mismatch ends the run at once.
    always_comb begin
        w_state_nxt     = r_state;
        w_elem_nxt      = r_elem;
        w_phase_nxt     = r_phase;
        w_addr_nxt      = r_addr;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_fail_elem_nxt = r_fail_elem;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_data_nxt = r_fail_data;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt     = S_RUN;
                    w_elem_nxt      = 3'd0;
                    w_phase_nxt     = 1'b0;
                    w_addr_nxt      = ADDR_ZERO;
                    w_done_nxt      = 1'b0;
                    w_pass_nxt      = 1'b0;
                    w_fail_elem_nxt = 3'd0;
                    w_fail_addr_nxt = ADDR_ZERO;
                    w_fail_data_nxt = DATA_ZERO;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RUN: begin
                if (w_mismatch) begin
                    w_state_nxt     = S_DONE;
                    w_elem_nxt      = 3'd0;
                    w_phase_nxt     = 1'b0;
                    w_addr_nxt      = ADDR_ZERO;
                    w_done_nxt      = 1'b1;
                    w_pass_nxt      = 1'b0;
                    w_fail_elem_nxt = r_elem;
                    w_fail_addr_nxt = r_addr;
                    w_fail_data_nxt = ram_rdata;
                end else if (w_two_ops && !r_phase) begin
                    w_phase_nxt = 1'b1;
                end else if (!w_last_addr) begin
                    w_phase_nxt = 1'b0;
                    w_addr_nxt  = w_down ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
                end else if (r_elem == 3'd5) begin
                    w_state_nxt = S_DONE;
                    w_elem_nxt  = 3'd0;
                    w_phase_nxt = 1'b0;
                    w_addr_nxt  = ADDR_ZERO;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = 1'b1;
                end else begin
                    // Elements 3 and 4 run downward, so they start at the top address.
                    w_elem_nxt  = r_elem + 3'd1;
                    w_phase_nxt = 1'b0;
                    w_addr_nxt  = ((r_elem == 3'd2) || (r_elem == 3'd3)) ? ADDR_MAX : ADDR_ZERO;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Port values for the next op, derived from where the sequencer lands.
    always_comb begin
        w_busy_nxt  = (w_state_nxt == S_RUN);
        w_en_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
        w_wdata_nxt = DATA_ZERO;
        if (w_state_nxt == S_RUN) begin
            w_en_nxt = 1'b1;
            w_we_nxt = (w_elem_nxt == 3'd0) || w_phase_nxt;
            if (w_we_nxt) begin
                w_wdata_nxt = ((w_elem_nxt == 3'd1) || (w_elem_nxt == 3'd3)) ? D1 : D0;
            end else begin
                w_wdata_nxt = DATA_ZERO;
            end
        end else begin
            w_en_nxt = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_elem      <= 3'd0;
            r_phase     <= 1'b0;
            r_addr      <= ADDR_ZERO;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_elem <= 3'd0;
            r_fail_addr <= ADDR_ZERO;
            r_fail_data <= DATA_ZERO;
            r_en        <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= DATA_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_elem      <= w_elem_nxt;
            r_phase     <= w_phase_nxt;
            r_addr      <= w_addr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_elem <= w_fail_elem_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_data <= w_fail_data_nxt;
            r_en        <= w_en_nxt;
            r_we        <= w_we_nxt;
            r_wdata     <= w_wdata_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_elem = r_fail_elem;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign ram_en    = r_en;
    assign ram_we    = r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: two instances (BG=00 with a fault-injectable RAM, BG=55 with a clean RAM),
// each op stream compared against a march C- reference built from the element table.
module tb_ram_march_bist;
    localparam int N = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start0, start1;
    logic       busy0, done0, pass0, en0, we0;
    logic       busy1, done1, pass1, en1, we1;
    logic [2:0] fe0, fe1;
    logic [6:0] fa0, fa1, addr0, addr1, ea0;
    logic [7:0] fd0, fd1, wd0, wd1, rd0, rd1;

    ram_march_bist dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_elem(fe0), .fail_addr(fa0), .fail_data(fd0), .ram_en(en0), .ram_we(we0),
        .ram_addr(addr0), .ram_wdata(wd0), .ram_rdata(rd0)
    );
    ram_march_bist #(.ADDR_W(7), .DATA_W(8), .BG(8'h55)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_elem(fe1), .fail_addr(fa1), .fail_data(fd1), .ram_en(en1), .ram_we(we1),
        .ram_addr(addr1), .ram_wdata(wd1), .ram_rdata(rd1)
    );

    // RAM models: fmode 0 = clean, 1 = stuck-at bit, 2 = addr[6] ignored (dut0 only)
    logic [7:0] mem0 [N];
    logic [7:0] mem1 [N];
    int         fmode;
    logic [6:0] faddr;
    logic [2:0] fbit;
    logic       fval;

    always_comb begin
        ea0 = (fmode == 2) ? {1'b0, addr0[5:0]} : addr0;
        rd0 = mem0[ea0];
        if (fmode == 1 && ea0 == faddr) rd0[fbit] = fval;
        rd1 = mem1[addr1];
    end

    always @(posedge clk) begin
        if (en0 && we0) mem0[ea0] <= wd0;
        if (en1 && we1) mem1[addr1] <= wd1;
    end

    int sel;
    logic       o_busy, o_done, o_pass, o_en, o_we;
    logic [2:0] o_fe;
    logic [6:0] o_fa, o_addr;
    logic [7:0] o_fd, o_wd;
    always_comb begin
        o_busy = sel != 0 ? busy1 : busy0;
        o_done = sel != 0 ? done1 : done0;
        o_pass = sel != 0 ? pass1 : pass0;
        o_en   = sel != 0 ? en1   : en0;
        o_we   = sel != 0 ? we1   : we0;
        o_fe   = sel != 0 ? fe1   : fe0;
        o_fa   = sel != 0 ? fa1   : fa0;
        o_fd   = sel != 0 ? fd1   : fd0;
        o_addr = sel != 0 ? addr1 : addr0;
        o_wd   = sel != 0 ? wd1   : wd0;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: march C- as a table of (read value, write value, direction) per element
    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
    } op_t;
    op_t        exp_q[$];
    logic       exp_fail;
    logic [2:0] exp_felem;
    logic [6:0] exp_faddr;
    logic [7:0] exp_fdata;
    logic [7:0] mm [N];
    int rd_tab [6] = '{-1, 0, 1, 0, 1, 0};
    int wr_tab [6] = '{0, 1, 0, 1, 0, -1};
    int dn_tab [6] = '{0, 0, 0, 1, 1, 0};

    task automatic build_model(input logic [7:0] bg, input bit faulty);
        exp_q.delete();
        exp_fail  = 1'b0;
        exp_felem = 3'd0;
        exp_faddr = 7'd0;
        exp_fdata = 8'd0;
        for (int i = 0; i < N; i++) mm[i] = 8'h00;
        for (int e = 0; e < 6 && !exp_fail; e++) begin
            for (int i = 0; i < N && !exp_fail; i++) begin
                logic [6:0] a;
                logic [6:0] ea;
                logic [7:0] v;
                logic [7:0] d;
                a  = (dn_tab[e] != 0) ? 7'(N - 1 - i) : 7'(i);
                ea = (faulty && fmode == 2) ? {1'b0, a[5:0]} : a;
                if (rd_tab[e] >= 0) begin
                    d = (rd_tab[e] != 0) ? ~bg : bg;
                    v = mm[ea];
                    if (faulty && fmode == 1 && ea == faddr) v[fbit] = fval;
                    exp_q.push_back({1'b0, a, d});
                    if (v !== d) begin
                        exp_fail  = 1'b1;
                        exp_felem = 3'(e);
                        exp_faddr = a;
                        exp_fdata = v;
                    end
                end
                if (!exp_fail && wr_tab[e] >= 0) begin
                    d      = (wr_tab[e] != 0) ? ~bg : bg;
                    mm[ea] = d;
                    exp_q.push_back({1'b1, a, d});
                end
            end
        end
    endtask

    task automatic drive_start(input int s, input logic v);
        if (s != 0) start1 = v;
        else        start0 = v;
    endtask

    task automatic run_test(input int s, input logic [7:0] bg, input bit faulty, input bit hold,
                            input int pre, output int ops, output int wes,
                            output logic [7:0] wd_first, output logic [7:0] wd_m1);
        op_t o;
        build_model(bg, faulty);
        sel      = s;
        ops      = 0;
        wes      = 0;
        wd_first = 8'h00;
        wd_m1    = 8'h00;
        repeat (pre) @(negedge clk);
        @(negedge clk);
        chk("pre_en", {o_en, o_we}, 2'b00);
        chk("pre_busy", o_busy, 1'b0);
        drive_start(s, 1'b1);
        @(negedge clk);
        if (!hold) drive_start(s, 1'b0);
        chk("start_clear", {o_busy, o_done, o_pass, o_fe, o_fa, o_fd}, {1'b1, 20'h0});
        while (o_busy === 1'b1 && ops < 2000) begin
            if (ops < exp_q.size()) o = exp_q[ops];
            else                    o = '0;
            chk("op", {o_en, o_we, o_addr, (o_we ? o_wd : 8'h00)},
                      {(ops < exp_q.size()), o.we, o.addr, (o.we ? o.data : 8'h00)});
            if (o_we) wes++;
            if (ops == 0)   wd_first = o_wd;
            if (ops == 129) wd_m1    = o_wd;
            ops++;
            if (hold && ops == exp_q.size() - 3) drive_start(s, 1'b0);
            @(negedge clk);
        end
        drive_start(s, 1'b0);
        chk("run_len", ops, exp_q.size());
        chk("end_flags", {o_busy, o_done, o_pass}, {1'b0, 1'b1, !exp_fail});
        chk("end_fail", {o_fe, o_fa, o_fd}, {exp_felem, exp_faddr, exp_fdata});
        chk("end_port", {o_en, o_we, o_addr, o_wd}, 17'h0);
        @(negedge clk);
        chk("done_held", {o_busy, o_done, o_en}, 3'b010);
    endtask

    int         ops, wes;
    logic [7:0] w_first, w_m1;

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        fmode  = 0;
        faddr  = 7'd0;
        fbit   = 3'd0;
        fval   = 1'b0;
        sel    = 0;
        repeat (3) @(negedge clk);
        chk("reset0", {busy0, done0, pass0, fe0, fa0, fd0, en0, we0, addr0, wd0}, 64'h0);
        chk("reset1", {busy1, done1, pass1, fe1, fa1, fd1, en1, we1, addr1, wd1}, 64'h0);
        rst_n = 1'b1;

        // clean 128x8
        run_test(0, 8'h00, 1'b1, 1'b0, 0, ops, wes, w_first, w_m1);
        chk("clean_len", ops, 1280);
        chk("clean_we", wes, 640);
        chk("clean_pass", o_pass, 1'b1);

        // mem[5] bit3 stuck-at-1
        fmode = 1; faddr = 7'd5; fbit = 3'd3; fval = 1'b1;
        run_test(0, 8'h00, 1'b1, 1'b0, 0, ops, wes, w_first, w_m1);
        chk("saf_len", ops, 139);
        chk("saf_info", {o_pass, o_fe, o_fa, o_fd}, {1'b0, 3'd1, 7'd5, 8'h08});

        // start in DONE after a failure, fault removed
        fmode = 0;
        run_test(0, 8'h00, 1'b1, 1'b0, 2, ops, wes, w_first, w_m1);
        chk("rerun_pass", {o_pass, 11'(ops)}, {1'b1, 11'd1280});

        // decoder alias: addr 64 maps to 0
        fmode = 2;
        run_test(0, 8'h00, 1'b1, 1'b0, 1, ops, wes, w_first, w_m1);
        chk("alias_info", {o_pass, o_fe, o_fa, o_fd}, {1'b0, 3'd1, 7'd64, 8'hFF});

        // start held high through RUN
        fmode = 0;
        run_test(0, 8'h00, 1'b1, 1'b1, 0, ops, wes, w_first, w_m1);
        chk("hold_len", ops, 1280);

        // asynchronous reset at op cycle 500
        sel = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (500) @(negedge clk);
        chk("midrun_busy", busy0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset", {busy0, done0, pass0, fe0, fa0, fd0, en0, we0, addr0, wd0}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_test(0, 8'h00, 1'b1, 1'b0, 0, ops, wes, w_first, w_m1);
        chk("post_reset_pass", {o_pass, 11'(ops)}, {1'b1, 11'd1280});

        // random stuck-at faults; march C- must catch every one
        for (int t = 0; t < 4; t++) begin
            fmode = 1;
            faddr = 7'($urandom_range(0, N - 1));
            fbit  = 3'($urandom_range(0, 7));
            fval  = 1'($urandom_range(0, 1));
            run_test(0, 8'h00, 1'b1, 1'b0, int'($urandom_range(0, 5)), ops, wes, w_first, w_m1);
            chk("rnd_saf_fail", {o_done, o_pass, o_fa}, {1'b1, 1'b0, faddr});
        end
        fmode = 0;

        // BG = 55
        run_test(1, 8'h55, 1'b0, 1'b0, 0, ops, wes, w_first, w_m1);
        chk("bg55_m0_wdata", w_first, 8'h55);
        chk("bg55_m1_wdata", w_m1, 8'hAA);
        chk("bg55_pass", {o_pass, 11'(ops)}, {1'b1, 11'd1280});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
